// File: rtl/rv_pkg.sv
// Shared write-back types: register index and the {rd, data} bundle
// carried by the long-latency FIFO and the register-file write port.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t          rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous circular FIFO for long-latency write-back entries.
// Ports: clk, reset (async, active-high), push/din, pop/dout, full, empty, count.
module wb_fifo
  import rv_pkg::*;
#(
  parameter  int  DEPTH = 4,
  parameter  type T     = wb_req_t,
  localparam int  AW    = $clog2(DEPTH),
  localparam int  CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results (strict priority) merged with buffered
// long-latency results into the registered register-file write port
// (we3/A3/wr_data3), plus a pending-write scoreboard (busy).
// Ports: clk, reset (async, active-high); alu_valid/alu_rd/alu_data;
// ll_valid/ll_ready/ll_rd/ll_data; issue_valid/issue_rd; we3, A3, wr_data3;
// busy. Optional macro WB_STATS_EN adds defer_cnt and ll_full_cnt.
module wb_arbiter
  import rv_pkg::*;
#(
  parameter  int XLEN  = rv_pkg::XLEN,
  parameter  int DEPTH = 4,
  parameter  int NREG  = rv_pkg::NREG,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  reg_idx_t        alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ll_valid,
  output logic            ll_ready,
  input  reg_idx_t        ll_rd,
  input  logic [XLEN-1:0] ll_data,
  input  logic            issue_valid,
  input  reg_idx_t        issue_rd,
  output logic            we3,
  output reg_idx_t        A3,
  output logic [XLEN-1:0] wr_data3,
  output logic [NREG-1:0] busy
`ifdef WB_STATS_EN
  ,
  output logic [15:0]     defer_cnt,
  output logic [15:0]     ll_full_cnt
`endif
);

  wb_req_t         head;
  wb_req_t         ll_req;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            alu_win;
  logic            push;
  logic            pop;
  logic [NREG-1:0] busy_nxt;

  // x0 writes are dropped: they neither win arbitration nor get stored.
  assign alu_win  = alu_valid && (alu_rd != '0);
  assign pop      = !alu_win && !fifo_empty;

  // Ready comes only from the registered count, so a full FIFO
  // refuses a push even in a cycle where it pops.
  assign ll_ready = (fifo_count != CW'(DEPTH));
  assign push     = ll_valid && !fifo_full && (ll_rd != '0);

  assign ll_req.rd   = ll_rd;
  assign ll_req.data = ll_data;

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (wb_req_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (ll_req),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3      <= 1'b0;
      A3       <= '0;
      wr_data3 <= '0;
    end else begin
      we3 <= alu_win || pop;
      unique case (1'b1)
        alu_win: begin
          A3       <= alu_rd;
          wr_data3 <= alu_data;
        end
        pop: begin
          A3       <= head.rd;
          wr_data3 <= head.data;
        end
        default: begin
          A3       <= A3;
          wr_data3 <= wr_data3;
        end
      endcase
    end
  end

  // Clear on write-back of a buffered entry; a same-cycle issue to
  // the same register is applied afterwards so set wins.
  always_comb begin
    busy_nxt = busy;
    if (pop)
      busy_nxt[head.rd] = 1'b0;
    if (issue_valid && (issue_rd != '0))
      busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      defer_cnt   <= '0;
      ll_full_cnt <= '0;
    end else begin
      if (alu_win && !fifo_empty && (defer_cnt != 16'hFFFF))
        defer_cnt <= defer_cnt + 16'd1;
      if (ll_valid && !ll_ready && (ll_full_cnt != 16'hFFFF))
        ll_full_cnt <= ll_full_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_wb_arbiter;
  import rv_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  reg_idx_t    alu_rd;
  logic [31:0] alu_data;
  logic        ll_valid;
  logic        ll_ready;
  reg_idx_t    ll_rd;
  logic [31:0] ll_data;
  logic        issue_valid;
  reg_idx_t    issue_rd;
  logic        we3;
  reg_idx_t    A3;
  logic [31:0] wr_data3;
  logic [31:0] busy;
`ifdef WB_STATS_EN
  logic [15:0] defer_cnt;
  logic [15:0] ll_full_cnt;
  int          m_defer;
  int          m_llfull;
`endif

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ll_valid    (ll_valid),
    .ll_ready    (ll_ready),
    .ll_rd       (ll_rd),
    .ll_data     (ll_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .we3         (we3),
    .A3          (A3),
    .wr_data3    (wr_data3),
    .busy        (busy)
`ifdef WB_STATS_EN
    ,
    .defer_cnt   (defer_cnt),
    .ll_full_cnt (ll_full_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_req_t     q[$];
  logic [31:0] m_busy;
  logic        m_we;
  reg_idx_t    m_a3;
  logic [31:0] m_wd;
  logic        m_acc;
  int          errors;
  int          checks;
  int          pend[$];

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    chk("we3", 64'(we3), 64'(m_we));
    chk("A3", 64'(A3), 64'(m_a3));
    chk("wr_data3", 64'(wr_data3), 64'(m_wd));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("ll_ready", 64'(ll_ready), 64'(q.size() < DEPTH));
    chk("count", 64'(dut.fifo_count), 64'(q.size()));
`ifdef WB_STATS_EN
    chk("defer_cnt", 64'(defer_cnt), 64'(m_defer));
    chk("ll_full_cnt", 64'(ll_full_cnt), 64'(m_llfull));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = '0;
    m_we   = 1'b0;
    m_a3   = '0;
    m_wd   = '0;
    m_acc  = 1'b0;
`ifdef WB_STATS_EN
    m_defer  = 0;
    m_llfull = 0;
`endif
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    ll_valid    = 1'b0;
    issue_valid = 1'b0;
  endtask

  // Apply the current inputs for one cycle, advance the model by the
  // write-back rules, then compare at the following falling edge.
  task automatic tick();
    logic    ready;
    logic    alu_win;
    logic    pop_hit;
    wb_req_t h;
    ready   = q.size() < DEPTH;
    alu_win = alu_valid && alu_rd != 0;
    pop_hit = !alu_win && q.size() > 0 && q[0].rd == issue_rd;
    assert (!(issue_valid && issue_rd != 0 && m_busy[issue_rd] && !pop_hit))
      else $error("protocol: issue to busy rd %0d", issue_rd);
    assert (!(alu_win && m_busy[alu_rd]))
      else $error("protocol: alu write to busy rd %0d", alu_rd);
    m_acc = ll_valid && ready;
`ifdef WB_STATS_EN
    if (alu_win && q.size() > 0 && m_defer < 65535) m_defer++;
    if (ll_valid && !ready && m_llfull < 65535) m_llfull++;
`endif
    if (alu_win) begin
      m_we = 1'b1;
      m_a3 = alu_rd;
      m_wd = alu_data;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      m_we = 1'b1;
      m_a3 = h.rd;
      m_wd = h.data;
      m_busy[h.rd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (m_acc && ll_rd != 0) begin
      h.rd   = ll_rd;
      h.data = ll_data;
      q.push_back(h);
    end
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  task automatic issue(int r);
    idle();
    issue_valid = 1'b1;
    issue_rd    = reg_idx_t'(r);
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    idle();
    alu_rd = '0; alu_data = '0;
    ll_rd = '0; ll_data = '0; issue_rd = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;

    // ALU only
    alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    tick();
    chk("alu_we", 64'(we3), 64'd1);
    chk("alu_a3", 64'(A3), 64'd5);
    chk("alu_data", 64'(wr_data3), 64'hDEADBEEF);
    idle();
    tick();
    chk("alu_we_off", 64'(we3), 64'd0);

    // ALU priority over a buffered entry
    issue(7);
    ll_valid = 1'b1; ll_rd = 7; ll_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 3; alu_data = 32'hA0;
    tick();
    chk("prio_a3_0", 64'(A3), 64'd3);
    ll_valid = 1'b0; alu_data = 32'hA1;
    tick();
    chk("prio_a3_1", 64'(A3), 64'd3);
    chk("prio_busy7_held", 64'(busy[7]), 64'd1);
    idle();
    tick();
    chk("prio_a3_ll", 64'(A3), 64'd7);
    chk("prio_data_ll", 64'(wr_data3), 64'h11);
    chk("prio_busy7_clr", 64'(busy[7]), 64'd0);

    // Fill, back-pressure, in-order drain with pointer wrap
    for (int r = 1; r <= 5; r++) issue(r);
    for (int r = 1; r <= 4; r++) begin
      alu_valid = 1'b1; alu_rd = 10; alu_data = 32'(r);
      ll_valid = 1'b1; ll_rd = reg_idx_t'(r); ll_data = 32'(100 + r);
      tick();
    end
    chk("full_ready", 64'(ll_ready), 64'd0);
    ll_rd = 5; ll_data = 32'd105;
    tick();
    chk("full_hold_cnt", 64'(dut.fifo_count), 64'd4);
    chk("full_hold_rdy", 64'(ll_ready), 64'd0);
    alu_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (m_acc) ll_valid = 1'b0;
      chk("drain_a3", 64'(A3), 64'(k));
      chk("drain_data", 64'(wr_data3), 64'(100 + k));
    end
    idle();
    tick();

    // Scoreboard race: pop of rd 9 and issue to rd 9 together
    issue(9);
    ll_valid = 1'b1; ll_rd = 9; ll_data = 32'h9;
    tick();
    ll_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 9;
    tick();
    chk("race_a3", 64'(A3), 64'd9);
    chk("race_busy9", 64'(busy[9]), 64'd1);
    idle();
    ll_valid = 1'b1; ll_rd = 9; ll_data = 32'h99;
    tick();
    ll_valid = 1'b0;
    tick();
    chk("race_clean", 64'(busy[9]), 64'd0);

    // x0 handling
    issue(12);
    ll_valid = 1'b1; ll_rd = 12; ll_data = 32'hC;
    tick();
    ll_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 0; alu_data = 32'hFFFF;
    tick();
    chk("x0_alu_a3", 64'(A3), 64'd12);
    chk("x0_alu_we", 64'(we3), 64'd1);
    idle();
    ll_valid = 1'b1; ll_rd = 0; ll_data = 32'h55;
    tick();
    chk("x0_ll_cnt", 64'(dut.fifo_count), 64'd0);
    ll_valid = 1'b0;
    tick();
    chk("x0_ll_we", 64'(we3), 64'd0);
    issue(0);
    chk("x0_issue", 64'(busy[0]), 64'd0);

    // Reset mid-operation
    for (int r = 5; r <= 7; r++) issue(r);
    for (int r = 5; r <= 7; r++) begin
      alu_valid = 1'b1; alu_rd = 20; alu_data = 32'(r);
      ll_valid = 1'b1; ll_rd = reg_idx_t'(r); ll_data = 32'(r);
      tick();
    end
    chk("pre_rst_busy", 64'(busy), 64'h0000_00E0);
    chk("pre_rst_cnt", 64'(dut.fifo_count), 64'd3);
    #2 reset = 1'b1;
    idle();
    #1;
    chk("rst_we3", 64'(we3), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_we", 64'(we3), 64'd0);
      chk("post_rst_rdy", 64'(ll_ready), 64'd1);
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      alu_valid = 1'($urandom % 2);
      alu_rd    = reg_idx_t'($urandom % 32);
      alu_data  = $urandom;
      if (m_busy[alu_rd]) alu_valid = 1'b0;
      issue_valid = ($urandom % 4) == 0;
      issue_rd    = reg_idx_t'($urandom % 32);
      if (m_busy[issue_rd]) issue_valid = 1'b0;
      if (alu_valid && alu_rd == issue_rd) issue_valid = 1'b0;
      if (!ll_valid) begin
        if (pend.size() > 0 && ($urandom % 2) == 1) begin
          int idx;
          idx = int'($urandom % pend.size());
          ll_rd = reg_idx_t'(pend[idx]);
          pend.delete(idx);
          ll_data  = $urandom;
          ll_valid = 1'b1;
        end else if (($urandom % 16) == 0) begin
          ll_rd    = 0;
          ll_data  = $urandom;
          ll_valid = 1'b1;
        end
      end
      tick();
      if (m_acc) ll_valid = 1'b0;
      if (issue_valid && issue_rd != 0) pend.push_back(int'(issue_rd));
    end

    // Bounded drain of everything still in flight
    alu_valid = 1'b0;
    issue_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!ll_valid && pend.size() > 0) begin
        ll_rd    = reg_idx_t'(pend.pop_front());
        ll_data  = $urandom;
        ll_valid = 1'b1;
      end
      if (!ll_valid && pend.size() == 0 && q.size() == 0) break;
      tick();
      if (m_acc) ll_valid = 1'b0;
    end
    chk("drain_done", 64'(pend.size() + q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
